// File: rtl/rgb_unpack.sv
// Unpacks 32-bit memory words (3 words = 4 pixels) into a stream of 24-bit RGB pixels,
// with frame delimiting, a per-frame pixel counter and a sticky framing error.
module rgb_unpack #(
    parameter int CNT_W   = 16,
    parameter bit SWAP_RB = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [23:0]      pixel,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             pix_last,
    output logic [CNT_W-1:0] pix_count,
    output logic             frame_err
);

    typedef enum logic [1:0] {R0, R1, R2, R3} res_e;

    res_e             res_q, res_d;
    logic [23:0]      buf_q, buf_d;
    logic             pendLast_q, pendLast_d;
    logic             err_q;
    logic             errSet;
    logic [23:0]      pixel_q;
    logic             valid_q;
    logic             last_q;
    logic [CNT_W-1:0] count_q;

    logic             slotFree;
    logic             accept;
    logic             emit;
    logic [23:0]      assembled;
    logic [23:0]      swapped;
    logic             emitLast;

    assign slotFree = !valid_q || pix_ready;
    assign in_ready = (res_q != R3) && slotFree;
    assign accept   = in_valid && in_ready;
    assign emit     = slotFree && (accept || (res_q == R3));

    // Next residue state and assembled pixel, assuming an emit happens this cycle.
    always_comb begin
        assembled  = buf_q;
        res_d      = res_q;
        buf_d      = buf_q;
        pendLast_d = pendLast_q;
        emitLast   = 1'b0;
        errSet     = 1'b0;
        case (res_q)
            R0: begin
                assembled = in_data[23:0];
                buf_d     = {16'h0000, in_data[31:24]};
                res_d     = R1;
            end
            R1: begin
                assembled = {in_data[15:0], buf_q[7:0]};
                buf_d     = {8'h00, in_data[31:16]};
                res_d     = R2;
            end
            R2: begin
                assembled  = {in_data[7:0], buf_q[15:0]};
                buf_d      = in_data[31:8];
                res_d      = R3;
                pendLast_d = in_last;
            end
            default: begin
                assembled  = buf_q;
                buf_d      = 24'h000000;
                res_d      = R0;
                emitLast   = pendLast_q;
                pendLast_d = 1'b0;
            end
        endcase
        // A frame ending before a whole pixel is buffered drops the residue.
        if ((res_q == R0 || res_q == R1) && in_last) begin
            emitLast = 1'b1;
            res_d    = R0;
            buf_d    = 24'h000000;
            errSet   = 1'b1;
        end
    end

    assign swapped = SWAP_RB ? {assembled[7:0], assembled[15:8], assembled[23:16]} : assembled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q      <= R0;
            buf_q      <= 24'h000000;
            pendLast_q <= 1'b0;
            err_q      <= 1'b0;
            pixel_q    <= 24'h000000;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            count_q    <= '0;
        end else if (emit) begin
            res_q      <= res_d;
            buf_q      <= buf_d;
            pendLast_q <= pendLast_d;
            err_q      <= err_q | errSet;
            pixel_q    <= swapped;
            valid_q    <= 1'b1;
            last_q     <= emitLast;
            count_q    <= last_q ? CNT_W'(1) : count_q + CNT_W'(1);
        end else if (pix_ready) begin
            valid_q    <= 1'b0;
        end
    end

    assign pixel     = pixel_q;
    assign pix_valid = valid_q;
    assign pix_last  = last_q;
    assign pix_count = count_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_rgb_unpack.sv
// Directed self-checking bench for rgb_unpack; a second instance checks the SWAP_RB byte order.
module tb_rgb_unpack;

    localparam logic [31:0] W1 = 32'h44112233;
    localparam logic [31:0] W2 = 32'h88776655;
    localparam logic [31:0] W3 = 32'hCCBBAA99;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [23:0] pixel;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic [15:0] pix_count;
    logic        frame_err;

    logic        swInReady;
    logic [23:0] swPixel;
    logic        swValid;
    logic        swLast;
    logic [15:0] swCount;
    logic        swErr;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    rgb_unpack #(.CNT_W(16), .SWAP_RB(1'b0)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .pixel(pixel), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .pix_count(pix_count), .frame_err(frame_err)
    );

    rgb_unpack #(.CNT_W(16), .SWAP_RB(1'b1)) dutSwap (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(swInReady),
        .in_last(in_last), .pixel(swPixel), .pix_valid(swValid), .pix_ready(pix_ready),
        .pix_last(swLast), .pix_count(swCount), .frame_err(swErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [31:0] data, input logic valid, input logic last,
                                 input logic ready);
        in_data   = data;
        in_valid  = valid;
        in_last   = last;
        pix_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic expectPixel(input string tag, input logic [23:0] pix, input logic [15:0] cnt,
                               input logic last);
        checkOutput({tag, ".pixel"}, {8'h00, pixel}, {8'h00, pix});
        checkOutput({tag, ".valid"}, {31'd0, pix_valid}, 32'd1);
        checkOutput({tag, ".count"}, {16'd0, pix_count}, {16'd0, cnt});
        checkOutput({tag, ".last"}, {31'd0, pix_last}, {31'd0, last});
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 32'h0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        pix_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.pixel", {8'h00, pixel}, 32'h0);
        checkOutput("rst.valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst.count", {16'd0, pix_count}, 32'd0);
        checkOutput("rst.err", {31'd0, frame_err}, 32'd0);
        checkOutput("rst.inReady", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Basic packing at full rate, with the swapped instance alongside.
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("pack1", 24'h112233, 16'd1, 1'b0);
        checkOutput("swap1", {8'h00, swPixel}, 32'h00332211);
        checkOutput("pack1.inReady", {31'd0, in_ready}, 32'd1);
        applyStimulus(W2, 1'b1, 1'b0, 1'b1);
        expectPixel("pack2", 24'h665544, 16'd2, 1'b0);
        checkOutput("swap2", {8'h00, swPixel}, 32'h00445566);
        applyStimulus(W3, 1'b1, 1'b0, 1'b1);
        expectPixel("pack3", 24'h998877, 16'd3, 1'b0);
        checkOutput("pack3.inReady", {31'd0, in_ready}, 32'd0);
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("pack4", 24'hCCBBAA, 16'd4, 1'b0);
        checkOutput("pack4.inReady", {31'd0, in_ready}, 32'd1);

        // Proper frame end on the third word.
        doReset();
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("frame1", 24'h112233, 16'd1, 1'b0);
        applyStimulus(W2, 1'b1, 1'b0, 1'b1);
        expectPixel("frame2", 24'h665544, 16'd2, 1'b0);
        applyStimulus(W3, 1'b1, 1'b1, 1'b1);
        expectPixel("frame3", 24'h998877, 16'd3, 1'b0);
        applyStimulus(W1, 1'b0, 1'b0, 1'b1);
        expectPixel("frame4", 24'hCCBBAA, 16'd4, 1'b1);
        checkOutput("frame4.err", {31'd0, frame_err}, 32'd0);
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("frameNext", 24'h112233, 16'd1, 1'b0);

        // Backpressure after the first pixel.
        doReset();
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("bp1", 24'h112233, 16'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(W2, 1'b1, 1'b0, 1'b0);
            expectPixel("bpHold", 24'h112233, 16'd1, 1'b0);
            checkOutput("bpHold.inReady", {31'd0, in_ready}, 32'd0);
        end
        applyStimulus(W2, 1'b1, 1'b0, 1'b1);
        expectPixel("bp2", 24'h665544, 16'd2, 1'b0);
        applyStimulus(W3, 1'b1, 1'b0, 1'b1);
        expectPixel("bp3", 24'h998877, 16'd3, 1'b0);
        applyStimulus(W1, 1'b0, 1'b0, 1'b1);
        expectPixel("bp4", 24'hCCBBAA, 16'd4, 1'b0);
        applyStimulus(W1, 1'b0, 1'b0, 1'b1);
        checkOutput("bpDrain.valid", {31'd0, pix_valid}, 32'd0);

        // Short frame: the residue is discarded and the error sticks.
        doReset();
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("short1", 24'h112233, 16'd1, 1'b0);
        applyStimulus(W2, 1'b1, 1'b1, 1'b1);
        expectPixel("short2", 24'h665544, 16'd2, 1'b1);
        checkOutput("short2.err", {31'd0, frame_err}, 32'd1);
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("shortNext", 24'h112233, 16'd1, 1'b0);
        checkOutput("shortNext.err", {31'd0, frame_err}, 32'd1);

        // Asynchronous reset in R2 while stalled, with frame_err set.
        applyStimulus(W2, 1'b1, 1'b0, 1'b1);
        expectPixel("mid2", 24'h665544, 16'd2, 1'b0);
        applyStimulus(W3, 1'b1, 1'b0, 1'b0);
        expectPixel("midStall", 24'h665544, 16'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("arst.pixel", {8'h00, pixel}, 32'h0);
        checkOutput("arst.valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("arst.last", {31'd0, pix_last}, 32'd0);
        checkOutput("arst.count", {16'd0, pix_count}, 32'd0);
        checkOutput("arst.err", {31'd0, frame_err}, 32'd0);
        checkOutput("arst.inReady", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(W1, 1'b1, 1'b0, 1'b1);
        expectPixel("arstNext", 24'h112233, 16'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
